// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage with EX/MEM and MEM/WB registers, aligned load/store bus access,
// wait-state stalling and bus timeout.
module mem_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_result,
    input  logic [31:0] in_sdata,
    input  logic [4:0]  in_mem_op,
    input  logic [4:0]  in_rd,
    input  logic        in_rd_en,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic [31:0] memdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_rd_en,
    output logic [31:0] wb_data,
    output logic        misalign,
    output logic        bus_err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic {S_IDLE, S_WAIT} state_t;
    state_t          state;
    logic [CW-1:0]   cnt;
    logic            v, rd_en;
    logic [31:0]     res, sd;
    logic [4:0]      op, rd;
    logic            is_load, is_store, mis, tout, berr;
    logic [1:0]      size;
    logic [7:0]      byte_l;
    logic [15:0]     half_l;
    logic [31:0]     ld_data;
    always_comb begin
        is_load    = op[3];
        is_store   = op[4] & ~op[3];
        size       = (op[1:0] == 2'b11) ? 2'b10 : op[1:0];
        mis        = v & (is_load | is_store) &
                     ((size == 2'b01 & res[0]) | (size == 2'b10 & res[1:0] != 2'b00));
        dmem_req   = v & (is_load | is_store) & ~mis;
        tout       = (state == S_WAIT) && (cnt == CW'(TIMEOUT));
        mem_stall  = dmem_req & ~dmem_ready & ~tout;
        berr       = tout & ~dmem_ready;
        dmem_we    = is_store;
        dmem_addr  = {res[31:2], 2'b00};
        dmem_wdata = size == 2'b00 ? {4{sd[7:0]}} : size == 2'b01 ? {2{sd[15:0]}} : sd;
        dmem_wstrb = ~is_store ? 4'b0000 :
                     size == 2'b00 ? 4'b0001 << res[1:0] :
                     size == 2'b01 ? 4'b0011 << res[1:0] : 4'b1111;
        byte_l     = dmem_rdata[{res[1:0], 3'b000} +: 8];
        half_l     = res[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        ld_data    = size == 2'b00 ? {{24{~op[2] & byte_l[7]}}, byte_l} :
                     size == 2'b01 ? {{16{~op[2] & half_l[15]}}, half_l} : dmem_rdata;
    end
    assign memdata = wb_data;
    always_ff @(posedge clk) begin
        if (rst) begin
            {v, res, sd, op, rd, rd_en} <= '0;
            {wb_valid, wb_rd, wb_rd_en, wb_data, misalign, bus_err} <= '0;
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            if (!mem_stall) begin
                v        <= in_valid;
                res      <= in_result;
                sd       <= in_sdata;
                op       <= in_mem_op;
                rd       <= in_rd;
                rd_en    <= in_rd_en;
                wb_valid <= v;
                wb_rd    <= rd;
                wb_rd_en <= v & rd_en & (rd != 5'd0) & ~is_store & ~mis & ~berr;
                wb_data  <= is_load ? ld_data : res;
                misalign <= mis;
                bus_err  <= berr;
            end
            // the cycle that raised the request already counts as the first wait cycle
            if (state == S_IDLE) begin
                if (dmem_req & ~dmem_ready) begin
                    state <= S_WAIT;
                    cnt   <= CW'(1);
                end
            end else if (dmem_ready | tout) begin
                state <= S_IDLE;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a behavioural memory-stage model.
module tb_mem_stage;
    localparam int T = 4;
    logic        clk = 0, rst = 1;
    logic        in_valid = 0, in_rd_en = 0;
    logic [31:0] in_result = 0, in_sdata = 0;
    logic [4:0]  in_mem_op = 0, in_rd = 0;
    logic        dmem_req, dmem_we, dmem_ready = 0;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 0;
    logic [3:0]  dmem_wstrb;
    logic        mem_stall, wb_valid, wb_rd_en, misalign, bus_err;
    logic [31:0] memdata, wb_data;
    logic [4:0]  wb_rd;
    int n_cmp = 0, n_bad = 0;

    mem_stage #(.TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_result(in_result), .in_sdata(in_sdata),
        .in_mem_op(in_mem_op), .in_rd(in_rd), .in_rd_en(in_rd_en), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .memdata(memdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_rd_en(wb_rd_en), .wb_data(wb_data),
        .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // lat = idle cycles before dmem_ready rises; -1 means the bus never answers
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [4:0] rd, input logic rd_en,
                          input int lat, input logic [31:0] rdata);
        bit ld, st, uns, mis, mem, ok, be, done;
        int sz, sh, exp_stalls, stalls, cyc;
        logic [31:0] exp_data, exp_wdata, b, h;
        logic [3:0] exp_strb;
        ld  = op[3];
        st  = op[4] && !op[3];
        uns = op[2];
        sz  = (op[1:0] == 2'b11) ? 2 : int'(op[1:0]);
        sh  = int'(addr % 4);
        mis = (ld || st) && ((sz == 1 && addr % 2 != 0) || (sz == 2 && sh != 0));
        mem = (ld || st) && !mis;
        ok  = lat >= 0 && lat <= T;
        be  = mem && !ok;
        exp_stalls = mem ? (ok ? lat : T) : 0;
        b = (rdata >> (8 * sh)) % 256;
        h = (rdata >> (16 * (sh / 2))) % 65536;
        if (!uns && b >= 128) b = b + 32'hFFFFFF00;
        if (!uns && h >= 32768) h = h + 32'hFFFF0000;
        exp_data  = !ld ? addr : sz == 0 ? b : sz == 1 ? h : rdata;
        exp_wdata = sz == 0 ? (sd % 256) * 32'h01010101 : sz == 1 ? (sd % 65536) * 32'h00010001 : sd;
        exp_strb  = !st ? 4'd0 : sz == 0 ? 4'(1 << sh) : sz == 1 ? 4'(3 << sh) : 4'hF;
        @(negedge clk);
        in_valid = 1; in_mem_op = op; in_result = addr; in_sdata = sd; in_rd = rd; in_rd_en = rd_en;
        @(negedge clk);
        in_valid = 0;
        stalls = 0; cyc = 0; done = 0;
        while (cyc < 40) begin
            dmem_ready = (lat >= 0 && cyc >= lat);
            dmem_rdata = dmem_ready ? rdata : $urandom;
            #1;
            if (cyc == 0) begin
                check({tag, " req"}, dmem_req, mem);
                if (mem) begin
                    check({tag, " we"}, dmem_we, st);
                    check({tag, " addr"}, dmem_addr, addr & 32'hFFFFFFFC);
                    check({tag, " wstrb"}, dmem_wstrb, exp_strb);
                    if (st) check({tag, " wdata"}, dmem_wdata, exp_wdata);
                end
            end
            if (!mem_stall) begin
                done = 1;
                break;
            end
            stalls++;
            @(negedge clk);
            cyc++;
        end
        if (!done) check({tag, " stall bound"}, 0, 1);
        @(posedge clk);
        #1 dmem_ready = 0;
        @(negedge clk);
        check({tag, " stalls"}, stalls, exp_stalls);
        check({tag, " wb_valid"}, wb_valid, 1);
        check({tag, " wb_rd"}, wb_rd, rd);
        check({tag, " wb_rd_en"}, wb_rd_en, rd_en && rd != 0 && !st && !mis && !be);
        check({tag, " misalign"}, misalign, mis);
        check({tag, " bus_err"}, bus_err, be);
        if (!(ld && (mis || be))) begin
            check({tag, " wb_data"}, wb_data, exp_data);
            check({tag, " memdata"}, memdata, exp_data);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset wb_valid", wb_valid, 0);
        check("reset wb_rd_en", wb_rd_en, 0);
        check("reset wb_data", wb_data, 0);
        check("reset req", dmem_req, 0);
        check("reset stall", mem_stall, 0);
        check("reset flags", {misalign, bus_err}, 0);
        rst = 0;
        run_op("lb zero-wait", 5'b01000, 32'h1003, 0, 5'd5, 1, 0, 32'h80AABBCC);
        check("lb literal", wb_data, 32'hFFFFFF80);
        run_op("lhu 3-wait", 5'b01101, 32'h2002, 0, 5'd6, 1, 3, 32'h80011234);
        check("lhu literal", wb_data, 32'h00008001);
        run_op("sb", 5'b10000, 32'h3001, 32'h000000A5, 5'd7, 1, 0, 0);
        run_op("lw misaligned", 5'b01010, 32'h4002, 0, 5'd8, 1, 0, 32'h12345678);
        run_op("lw timeout", 5'b01010, 32'h4000, 0, 5'd9, 1, -1, 0);
        run_op("after timeout", 5'b00000, 32'hCAFEF00D, 0, 5'd10, 1, 0, 0);
        run_op("ld+st as load", 5'b11011, 32'h5008, 32'h11111111, 5'd11, 1, 1, 32'hDEADBEEF);
        run_op("lw ready at T", 5'b01010, 32'h500C, 0, 5'd12, 1, T, 32'h0BADF00D);
        run_op("sh upper", 5'b10001, 32'h6002, 32'h0000BEEF, 5'd1, 1, 2, 0);
        run_op("rd zero", 5'b01010, 32'h7000, 0, 5'd0, 1, 0, 32'h55AA55AA);
        // reset during the second wait cycle with ready arriving at the same time
        @(negedge clk);
        in_valid = 1; in_mem_op = 5'b01010; in_result = 32'h8000; in_rd = 5'd3; in_rd_en = 1;
        @(negedge clk);
        in_valid = 0;
        repeat (2) @(negedge clk);
        rst = 1; dmem_ready = 1; dmem_rdata = 32'h77777777;
        @(posedge clk);
        #1 rst = 0; dmem_ready = 0;
        #1;
        check("rst-in-wait req", dmem_req, 0);
        check("rst-in-wait stall", mem_stall, 0);
        check("rst-in-wait wb_valid", wb_valid, 0);
        check("rst-in-wait wb_rd_en", wb_rd_en, 0);
        @(negedge clk);
        check("rst-in-wait later wb_valid", wb_valid, 0);
        check("rst-in-wait bus_err", bus_err, 0);
        for (int i = 0; i < 150; i++) begin
            logic [4:0] op;
            op = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
            run_op("random", op, $urandom, $urandom, 5'($urandom), 1'($urandom),
                   int'($urandom_range(0, 7)) - 1, $urandom);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have ports from execute: in_valid in 1; in_result in 32 (ALU result/effective address); in_sdata in 32 (forwarded rs2); in_mem_op in 5; in_rd in 5; in_rd_en in 1.
REQ-004 SHALL decode in_mem_op as: [4] store, [3] load, [2] unsigned load, [1:0] size (00 byte, 01 half, 10 word, 11 reserved).
REQ-005 SHALL have data-memory ports: dmem_req out 1; dmem_we out 1; dmem_addr out 32 (word-aligned); dmem_wdata out 32; dmem_wstrb out 4; dmem_ready in 1; dmem_rdata in 32, valid when dmem_ready=1.
REQ-006 SHALL have outputs: mem_stall out 1 (freezes execute and earlier stages); memdata out 32 (forwarding value to execute); wb_valid out 1; wb_rd out 5; wb_rd_en out 1; wb_data out 32; misalign out 1; bus_err out 1.
REQ-007 SHALL have parameter TIMEOUT, default 255, maximum wait cycles before bus error.

Function
REQ-008 SHALL hold an EX/MEM register (valid, result, sdata, mem_op, rd, rd_en) loaded from in_* on each edge with mem_stall=0, held unchanged while mem_stall=1.
REQ-009 SHALL treat an op with both load and store bits set as load; size 11 SHALL be treated as word.
REQ-010 SHALL flag misaligned when half access has addr[0]=1 or word access has addr[1:0]!=0; a misaligned op SHALL issue no memory request, SHALL not stall, and SHALL suppress its register write (wb_rd_en=0).
REQ-011 SHALL drive dmem_req=1 combinationally while the registered op is valid, load or store, aligned, and the FSM is IDLE or WAIT.
REQ-012 SHALL drive dmem_addr={addr[31:2],2'b00}, dmem_we=store.
REQ-013 SHALL replicate store data: byte -> sdata[7:0] x4, strobe 0001<<addr[1:0]; half -> sdata[15:0] x2, strobe 0011<<addr[1:0]; word -> sdata, strobe 1111; dmem_wstrb=0000 for loads.
REQ-014 SHALL run FSM IDLE -> WAIT when dmem_req=1 and dmem_ready=0; WAIT -> IDLE on dmem_ready=1 or timeout; IDLE stays IDLE on dmem_ready=1 in the request cycle (zero-wait access).
REQ-015 SHALL assert mem_stall=dmem_req & ~dmem_ready; a zero-wait access SHALL add no stall cycle.
REQ-016 SHALL count wait cycles in WAIT, cleared on entry to IDLE; on reaching TIMEOUT it SHALL end the access, deassert stall, and assert bus_err with the write suppressed.
REQ-017 SHALL select a load lane by addr[1:0] (half by addr[1]) and sign-extend unless in_mem_op[2]=1, in which case it SHALL zero-extend.
REQ-018 SHALL load the MEM/WB register on each edge with mem_stall=0: wb_valid=reg valid; wb_rd, wb_rd_en from the EX/MEM register; wb_data=extended load data for loads, else reg result; misalign and bus_err registered alongside, each set for one cycle.
REQ-019 SHALL hold MEM/WB unchanged while mem_stall=1, so a load completes with exactly one cycle of latency after dmem_ready.
REQ-020 SHALL drive memdata=wb_data.
REQ-021 SHALL produce wb_rd_en=0 whenever wb_rd=0 or wb_valid=0.
REQ-022 SHALL write stores to no register: wb_rd_en=0 regardless of in_rd_en.

Reset
REQ-023 SHALL on rst=1 clear both pipeline registers (all valid, enable, data fields to 0), set FSM to IDLE, clear the wait counter, and hold dmem_req, mem_stall, misalign and bus_err at 0 from the following cycle.
REQ-024 SHALL, on reset asserted during WAIT, abandon the access with no writeback and ignore a dmem_ready arriving in the same cycle.

Verification
REQ-025 SHALL pass: lb, addr 0x1003, rdata 0x80AABBCC, ready same cycle -> no stall, next-cycle wb_data=0xFFFFFF80, wb_rd_en=1.
REQ-026 SHALL pass: lhu, addr 0x2002, rdata 0x8001_1234, ready after 3 cycles -> mem_stall high exactly 3 cycles, then wb_data=0x00008001.
REQ-027 SHALL pass: sb, addr 0x3001, sdata 0x000000A5 -> dmem_wdata=0xA5A5A5A5, dmem_wstrb=0010, dmem_we=1, wb_rd_en=0.
REQ-028 SHALL pass: lw, addr 0x4002 -> dmem_req never asserted, misalign=1 for one cycle, wb_rd_en=0, no stall.
REQ-029 SHALL pass: lw, ready never asserted, TIMEOUT=4 -> stall 4 cycles, then bus_err=1 one cycle, wb_rd_en=0, next instruction accepted.
REQ-030 SHALL pass: rst=1 in second WAIT cycle of a load -> next cycle dmem_req=0, mem_stall=0, wb_valid=0.
